ssd_scan_driver: RTL and testbench
==================================

// Module: ssd_scan_driver
// PURPOSE
//  Downstream consumer of the 4-digit roller output (R3..R0, one 4-bit code per SSD digit).
//  Time-multiplexes the four digits onto a common-anode 4-digit seven-segment display.
//  Decodes each digit to hex glyphs (0-F), with optional leading-zero blanking.
//  Digits are snapshotted once per frame, so a mid-frame roller update never tears the display.
// PARAMETERS
//  SCAN_DIV   100000  clk cycles per digit slot (>=2); 1 kHz/digit at 100 MHz
//  BLANK_CYC  1000    cycles at slot start with all anodes off, for anti-ghosting (1 <= BLANK_CYC < SCAN_DIV)
// PORTS
//  clk         in   1  system clock; the only clock in the block
//  rst_n       in   1  synchronous, active-low reset
//  en          in   1  scan enable; 0 = freeze scan and blank the display
//  R3,R2,R1,R0 in   4  digit codes; R3 = leftmost digit
//  dp          in   4  decimal-point request per digit, active-high; dp[i] pairs with Ri
//  lz_blank    in   1  1 = blank leading zeros
//  an          out  4  anode enables, active-low; an[i] drives digit i
//  seg         out  7  segments {g,f,e,d,c,b,a}, active-low
//  dp_n        out  1  decimal-point segment, active-low
//  frame_done  out  1  one-cycle pulse each time a full 4-slot frame completes
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): cnt=0, sel=3, shadow digits/dp/lz=0, an=4'b1111, seg=7'h7F, dp_n=1, frame_done=0.
//  Slot counter cnt runs 0..SCAN_DIV-1 while en=1.
//   - At cnt==SCAN_DIV-1: cnt->0 and sel steps 3->2->1->0->3 (wraps 0->3).
//  Frame-start cycle = (cnt==0 && sel==3 && en). On it, shadow <= {R3..R0, dp, lz_blank}.
//   - The first frame-start is the first enabled cycle after reset release.
//  frame_done is registered: it is 1 in the cycle after the edge where cnt==SCAN_DIV-1, sel==0, en=1.
//  All outputs are registered and reflect (cnt, sel, shadow) of the previous cycle (1-cycle latency).
//   - If cnt < BLANK_CYC: an=4'b1111, seg=7'h7F, dp_n=1.
//   - Otherwise: an = 4'b1111 with bit sel cleared; seg = glyph(shadow digit sel); dp_n = ~shadow_dp[sel].
//   - BLANK_CYC >= 1 guarantees a freshly loaded shadow is never displayed mid-slot with stale data.
//  Glyphs (seg[6:0], active-low):
//   - 0=1000000  1=1111001  2=0100100  3=0110000  4=0011001  5=0010010  6=0000010  7=1111000
//   - 8=0000000  9=0010000  A=0001000  b=0000011  C=1000110  d=0100001  E=0000110  F=0001110
//  Leading-zero blank, applied when shadow_lz=1:
//   - Digit i (i=3..1) is blanked (seg=7'h7F) if it and every higher digit are 0.
//   - Digit 0 is never blanked.
//   - A blanked digit keeps its anode active and still shows its dp.
//  en=0: cnt, sel and shadow hold; outputs go to an=1111, seg=7F, dp_n=1 on the next edge; no shadow load; frame_done=0.
//   - On en=1 the scan resumes from the held cnt/sel (no restart).
//  rst_n=0 mid-frame: full reset on that edge; the partial frame is discarded and no frame_done is issued.
//  Inputs are sampled only on frame-start cycles; changes on other cycles affect only the next frame.
// TESTING  (SCAN_DIV=8, BLANK_CYC=2)
//  1. Reset, en=1, R={5,2,3,3}, dp=0, lz=0 -> per 8-cycle slot: 2 blank cycles, then 6 cycles of
//     an=0111/seg=0010010, then an=1011/0100100, an=1101/0110000, an=1110/0110000; frame_done every 32 cycles.
//  2. Change R3 from 5 to 9 during slot sel=1 -> digit 3 still shows 5 this frame; shows 0010000 from the next frame.
//  3. R={0,0,7,0}, lz=1 -> digits 3,2 seg=7F with anodes still cycling; digit 1 = 1111000; digit 0 = 1000000.
//     R={0,0,0,0}, lz=1 -> only digit 0 lit, showing 1000000.
//  4. Drop en for 20 cycles mid-slot -> outputs blank one cycle later and cnt/sel frozen;
//     on re-enable the slot finishes its remaining cycles with no frame_done glitch.
//  5. Pulse rst_n=0 for 1 cycle during sel=2 -> next cycle an=1111, seg=7F;
//     the scan restarts at sel=3 with a fresh snapshot; no frame_done for the aborted frame.
//  6. dp=4'b0100, R = hex {A,b,C,d} -> dp_n=0 only while an=1011;
//     glyphs 0001000, 0000011, 1000110, 0100001 in order.

Source files
------------

// File: rtl/ssd_scan_driver.sv
// ssd_scan_driver: time-multiplexes four hex digits onto a common-anode
// 4-digit seven-segment display. Digits are snapshotted once per frame,
// with optional leading-zero blanking and an anti-ghosting blank window
// at the start of every digit slot.
module ssd_scan_driver #(
  parameter int unsigned SCAN_DIV  = 100000,
  parameter int unsigned BLANK_CYC = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] R3,
  input  logic [3:0] R2,
  input  logic [3:0] R1,
  input  logic [3:0] R0,
  input  logic [3:0] dp,
  input  logic       lz_blank,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp_n,
  output logic       frame_done
);

  localparam int unsigned CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Scan state and frame snapshot
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       sel, sel_nxt;
  logic [15:0]      sh_dig, sh_dig_nxt;
  logic [3:0]       sh_dp, sh_dp_nxt;
  logic             sh_lz, sh_lz_nxt;

  // Next output values
  logic [3:0] an_nxt;
  logic [6:0] seg_nxt;
  logic       dp_n_nxt;
  logic       frame_done_nxt;

  // Digit currently selected and its leading-zero status
  logic [3:0]  cur_dig;
  logic [15:0] hi_digits;
  logic        lz_hit;

  // Hex glyph decode, segments {g,f,e,d,c,b,a} active-low
  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;
      4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    return g;
  endfunction

  // State register: slot counter, digit select and snapshot
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      sel    <= 2'd3;
      sh_dig <= '0;
      sh_dp  <= '0;
      sh_lz  <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      sel    <= sel_nxt;
      sh_dig <= sh_dig_nxt;
      sh_dp  <= sh_dp_nxt;
      sh_lz  <= sh_lz_nxt;
    end
  end

  // Next-state: advance the scan while enabled, snapshot on frame start
  always_comb begin
    cnt_nxt    = cnt;
    sel_nxt    = sel;
    sh_dig_nxt = sh_dig;
    sh_dp_nxt  = sh_dp;
    sh_lz_nxt  = sh_lz;
    if (en) begin
      if (cnt == CNT_LAST) begin
        cnt_nxt = '0;
        sel_nxt = sel - 2'd1;
      end else begin
        cnt_nxt = cnt + CNT_W'(1);
      end
      if ((cnt == '0) && (sel == 2'd3)) begin
        sh_dig_nxt = {R3, R2, R1, R0};
        sh_dp_nxt  = dp;
        sh_lz_nxt  = lz_blank;
      end
    end
  end

  // Output decode: blank window, anode select, glyph and leading-zero blank
  always_comb begin
    an_nxt         = 4'b1111;
    seg_nxt        = SEG_OFF;
    dp_n_nxt       = 1'b1;
    frame_done_nxt = en && (cnt == CNT_LAST) && (sel == 2'd0);
    cur_dig        = sh_dig[{sel, 2'b00} +: 4];
    hi_digits      = sh_dig >> {sel, 2'b00};
    lz_hit         = sh_lz && (sel != 2'd0) && (hi_digits == 16'd0);
    if (en && (cnt >= CNT_BLANK)) begin
      an_nxt   = ~(4'b0001 << sel);
      seg_nxt  = lz_hit ? SEG_OFF : glyph(cur_dig);
      dp_n_nxt = ~sh_dp[sel];
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an         <= 4'b1111;
      seg        <= SEG_OFF;
      dp_n       <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      an         <= an_nxt;
      seg        <= seg_nxt;
      dp_n       <= dp_n_nxt;
      frame_done <= frame_done_nxt;
    end
  end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Bench for ssd_scan_driver: directed scenarios followed by randomized
// traffic, every cycle checked against a frame-position reference model.
module tb_ssd_scan_driver;

  localparam int SCAN_DIV  = 8;
  localparam int BLANK_CYC = 2;
  localparam int FRAME     = 4 * SCAN_DIV;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] r3, r2, r1, r0;
  logic [3:0] dp;
  logic       lz_blank;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp_n;
  logic       frame_done;

  int checks   = 0;
  int failures = 0;

  // Reference model: position within the frame counted in enabled cycles
  int         m_pos;
  logic [15:0] m_dig;
  logic [3:0]  m_dp;
  logic        m_lz;

  logic [6:0] glyph_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  ssd_scan_driver #(.SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .R3(r3), .R2(r2), .R1(r1), .R0(r0),
    .dp(dp), .lz_blank(lz_blank),
    .an(an), .seg(seg), .dp_n(dp_n), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: predict outputs from the model, clock, update model, compare
  task automatic step();
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dpn;
    logic       e_fd;
    int         slot;
    int         off;
    e_an = 4'b1111; e_seg = 7'h7F; e_dpn = 1'b1; e_fd = 1'b0;
    if (rst_n && en) begin
      slot = 3 - (m_pos / SCAN_DIV);
      off  = m_pos % SCAN_DIV;
      e_fd = (m_pos == FRAME - 1);
      if (off >= BLANK_CYC) begin
        e_an       = 4'b1111;
        e_an[slot] = 1'b0;
        if (m_lz && slot > 0 && (m_dig >> (4 * slot)) == 16'd0)
          e_seg = 7'h7F;
        else
          e_seg = glyph_tab[(m_dig >> (4 * slot)) & 16'hF];
        e_dpn = ~m_dp[slot];
      end
    end
    @(posedge clk);
    if (!rst_n) begin
      m_pos = 0; m_dig = '0; m_dp = '0; m_lz = 1'b0;
    end else if (en) begin
      if (m_pos == 0) begin
        m_dig = {r3, r2, r1, r0}; m_dp = dp; m_lz = lz_blank;
      end
      m_pos = (m_pos + 1) % FRAME;
    end
    @(negedge clk);
    chk("an",         8'(an),         8'(e_an));
    chk("seg",        8'(seg),        8'(e_seg));
    chk("dp_n",       8'(dp_n),       8'(e_dpn));
    chk("frame_done", 8'(frame_done), 8'(e_fd));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_r(input logic [15:0] v);
    {r3, r2, r1, r0} = v;
  endtask

  int fd_count;

  initial begin
    m_pos = 0; m_dig = '0; m_dp = '0; m_lz = 1'b0;
    rst_n = 1'b0; en = 1'b0; set_r(16'h0); dp = 4'h0; lz_blank = 1'b0;
    @(negedge clk);

    // Reset state
    run(2);

    // Basic scan of 5,2,3,3
    rst_n = 1'b1; en = 1'b1; set_r(16'h5233);
    run(FRAME + 16);

    // Mid-frame change of R3 only shows from the next frame
    while (m_pos != 2 * SCAN_DIV + 3) step();
    r3 = 4'h9;
    run(2 * FRAME);

    // Leading-zero blanking
    while (m_pos != FRAME - 1) step();
    set_r(16'h0070); lz_blank = 1'b1;
    run(FRAME + 1);
    while (m_pos != FRAME - 1) step();
    set_r(16'h0000);
    run(FRAME + 1);

    // Enable drop mid-slot
    lz_blank = 1'b0; set_r(16'h1234);
    while (m_pos != SCAN_DIV + 4) step();
    en = 1'b0;
    run(20);
    en = 1'b1;
    run(FRAME);

    // Reset pulse during sel=2
    while (m_pos != SCAN_DIV + 5) step();
    set_r(16'h8E6F);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    fd_count = 0;
    for (int i = 0; i < FRAME; i++) begin
      step();
      if (frame_done) fd_count++;
    end
    chk("fd_after_reset", 8'(fd_count), 8'd1);

    // Hex glyphs with a single decimal point on digit 2
    while (m_pos != FRAME - 1) step();
    set_r(16'hABCD); dp = 4'b0100;
    run(FRAME + 1);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      en    = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 5) == 0) set_r(16'($urandom));
      if ($urandom_range(0, 9) == 0) dp = 4'($urandom);
      if ($urandom_range(0, 19) == 0) lz_blank = 1'($urandom);
      if ($urandom_range(0, 9) == 0) set_r(16'($urandom) & 16'h00FF);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
